dmem_arbiter: RTL and testbench

Shares the single data-memory port of `data_src` between two requesters: the CPU pipeline data port and the UART boot/debug loader. After reset it holds the CPU in a BOOT phase where only the loader may access memory. On `boot_done` it switches to RUN, where the CPU has fixed priority and a starvation counter guarantees the loader a slot. It sits between `pipeline_unit`/`mmio` and `data_src`. It also drives the pipeline run-enable.

---
 rtl/dmem_arbiter_pkg.sv | 36 +++
 rtl/dmem_arb_starve.sv | 45 ++++
 rtl/dmem_arbiter_chk.sv | 17 +
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner tag
// and the packed request bundle that is steered onto the memory port.
package dmem_arbiter_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned BE_W       = 4;

  typedef enum logic {
    ARB_BOOT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Idle memory command: every field low so an ungranted cycle drives zeros.
  function automatic mem_req_t mem_req_idle();
    mem_req_t r;
    r.we    = 1'b0;
    r.be    = {BE_W{1'b0}};
    r.addr  = {MEM_ADDR_W{1'b0}};
    r.wdata = {MEM_DATA_W{1'b0}};
    return r;
  endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Saturating loader starvation counter; force_gnt marks that the loader has
// waited STARVE_MAX ungranted RUN cycles and must win the next arbitration.
module dmem_arb_starve #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic l_req,
  input  logic l_gnt,
  output logic force_gnt
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  logic             at_max_s;

  assign at_max_s  = (starve_cnt_r == CNT_MAX);
  assign force_gnt = at_max_s;

  // Count ungranted loader wait cycles in RUN, clearing on grant or withdrawal.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!run || !l_req || l_gnt) begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (!at_max_s) begin
      starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1'b1);
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

endmodule

// File: rtl/dmem_arbiter_chk.sv
// Protocol invariants of the arbiter outputs: single grant, memory enable
// tracking the grants, and at most one read return per cycle.
module dmem_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic c_gnt,
  input logic l_gnt,
  input logic m_en,
  input logic c_rvalid,
  input logic l_rvalid
);

  a_one_gnt:    assert property (@(posedge clk) disable iff (!rst_n) !(c_gnt && l_gnt));
  a_en_follows: assert property (@(posedge clk) disable iff (!rst_n) m_en == (c_gnt | l_gnt));
  a_one_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(c_rvalid && l_rvalid));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: loader-only BOOT phase, then CPU-priority
// RUN phase with a guaranteed loader slot, plus a one-cycle read-return tag.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned STARVE_MAX = 8,
  parameter bit          BOOT_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [3:0]        c_be,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [3:0]        l_be,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              boot_done,
  output logic              cpu_run,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam arb_state_e RST_STATE = BOOT_EN ? ARB_BOOT : ARB_RUN;

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  arb_owner_e owner_r;
  logic       rd_r;
  logic       run_s;
  logic       force_s;
  logic       c_gnt_s;
  logic       l_gnt_s;
  mem_req_t   c_cmd_s;
  mem_req_t   l_cmd_s;
  mem_req_t   mux_s;

  assign run_s = (state_r == ARB_RUN);

  dmem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run_s),
    .l_req    (l_req),
    .l_gnt    (l_gnt_s),
    .force_gnt(force_s)
  );

  // BOOT leaves on boot_done; RUN is terminal until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_BOOT: begin
        if (boot_done) begin
          state_nxt_s = ARB_RUN;
        end else begin
          state_nxt_s = ARB_BOOT;
        end
      end
      ARB_RUN:  state_nxt_s = ARB_RUN;
      default:  state_nxt_s = RST_STATE;
    endcase
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Same-cycle grants; reset is included so nothing is granted while held low.
  always_comb begin
    c_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (!rst_n) begin
      c_gnt_s = 1'b0;
      l_gnt_s = 1'b0;
    end else if (!run_s) begin
      l_gnt_s = l_req;
    end else if (force_s && l_req) begin
      l_gnt_s = 1'b1;
    end else begin
      c_gnt_s = c_req;
      l_gnt_s = l_req & ~c_req;
    end
  end

  assign c_cmd_s = '{we: c_we, be: c_be, addr: MEM_ADDR_W'(c_addr), wdata: MEM_DATA_W'(c_wdata)};
  assign l_cmd_s = '{we: l_we, be: l_be, addr: MEM_ADDR_W'(l_addr), wdata: MEM_DATA_W'(l_wdata)};

  // Steer the granted command to memory, zeros when idle.
  always_comb begin
    mux_s = mem_req_idle();
    case ({c_gnt_s, l_gnt_s})
      2'b10:   mux_s = c_cmd_s;
      2'b01:   mux_s = l_cmd_s;
      default: mux_s = mem_req_idle();
    endcase
  end

  // Tag each granted read so the returning data reaches its requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r    <= 1'b0;
      owner_r <= OWN_CPU;
    end else begin
      rd_r <= (c_gnt_s & ~c_we) | (l_gnt_s & ~l_we);
      if (c_gnt_s && !c_we) begin
        owner_r <= OWN_CPU;
      end else if (l_gnt_s && !l_we) begin
        owner_r <= OWN_LDR;
      end else begin
        owner_r <= owner_r;
      end
    end
  end

  assign c_gnt    = c_gnt_s;
  assign l_gnt    = l_gnt_s;
  assign cpu_run  = run_s;
  assign m_en     = c_gnt_s | l_gnt_s;
  assign m_we     = mux_s.we;
  assign m_be     = mux_s.be;
  assign m_addr   = ADDR_W'(mux_s.addr);
  assign m_wdata  = DATA_W'(mux_s.wdata);
  assign c_rvalid = rd_r && (owner_r == OWN_CPU);
  assign l_rvalid = rd_r && (owner_r == OWN_LDR);
  assign c_rdata  = m_rdata;
  assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random bench for dmem_arbiter against a cycle-level model of the
// arbitration rules with its own copy of memory contents.
module tb_dmem_arbiter;

  localparam int SMAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, l_req, l_we, boot_done;
  logic [3:0]  c_be, l_be;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid, cpu_run, m_en, m_we;
  logic [31:0] c_rdata, l_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        b_c_gnt, b_c_rvalid, b_l_gnt, b_l_rvalid, b_cpu_run, b_m_en, b_m_we;
  logic [31:0] b_c_rdata, b_l_rdata, b_m_addr, b_m_wdata;
  logic [3:0]  b_m_be;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          total = 0;
  int          bad = 0;
  bit          m_run;
  int          m_wait;
  bit          p_valid, p_cpu;
  logic [31:0] p_data;
  bit          last_ec, last_el;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .BOOT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .boot_done(boot_done), .cpu_run(cpu_run),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Second instance that resets straight into RUN.
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .BOOT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
    .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(b_l_gnt), .l_rvalid(b_l_rvalid), .l_rdata(b_l_rdata),
    .boot_done(boot_done), .cpu_run(b_cpu_run),
    .m_en(b_m_en), .m_we(b_m_we), .m_be(b_m_be), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(m_rdata)
  );

  dmem_arbiter_chk u_chk (
    .clk(clk), .rst_n(rst_n), .c_gnt(c_gnt), .l_gnt(l_gnt), .m_en(m_en),
    .c_rvalid(c_rvalid), .l_rvalid(l_rvalid)
  );

  // Synchronous memory seen by the DUT memory port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      m_rdata <= 32'h0;
    end else if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= mem[m_addr[9:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Check every output against the model for this cycle, then advance one edge.
  task automatic model_cycle();
    bit          ec, el, ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr, ewd;
    if (!rst_n) begin
      m_run = 1'b0; m_wait = 0; p_valid = 1'b0;
    end
    ec = 1'b0; el = 1'b0;
    if (rst_n) begin
      if (!m_run) el = l_req;
      else if (l_req && m_wait >= SMAX) el = 1'b1;
      else begin
        ec = c_req;
        el = l_req && !c_req;
      end
    end
    ewe = 1'b0; ebe = 4'h0; eaddr = 32'h0; ewd = 32'h0;
    if (ec) begin ewe = c_we; ebe = c_be; eaddr = c_addr; ewd = c_wdata; end
    if (el) begin ewe = l_we; ebe = l_be; eaddr = l_addr; ewd = l_wdata; end
    chk("c_gnt", c_gnt, ec);
    chk("l_gnt", l_gnt, el);
    chk("m_en", m_en, ec | el);
    chk("m_we", m_we, ewe);
    chk("m_be", m_be, ebe);
    chk("m_addr", m_addr, eaddr);
    chk("m_wdata", m_wdata, ewd);
    chk("cpu_run", cpu_run, m_run);
    chk("c_rvalid", c_rvalid, p_valid && p_cpu);
    chk("l_rvalid", l_rvalid, p_valid && !p_cpu);
    if (p_valid && p_cpu) chk("c_rdata", c_rdata, p_data);
    if (p_valid && !p_cpu) chk("l_rdata", l_rdata, p_data);
    chk("noboot_cpu_run", b_cpu_run, 1'b1);
    last_ec = ec; last_el = el;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    end else begin
      p_valid = (ec || el) && !ewe;
      p_cpu   = ec;
      p_data  = ref_mem[eaddr[9:2]];
      if ((ec || el) && ewe)
        for (int b = 0; b < 4; b++)
          if (ebe[b]) ref_mem[eaddr[9:2]][8*b +: 8] = ewd[8*b +: 8];
      if (m_run && l_req && !el) m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
      else m_wait = 0;
      if (!m_run && boot_done) m_run = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; boot_done = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = 32'h0; c_wdata = 32'h0;
    l_req = 1'b1; l_we = 1'b0; l_be = 4'hF; l_addr = 32'h0; l_wdata = 32'h0;
    m_run = 1'b0; m_wait = 0; p_valid = 1'b0; p_cpu = 1'b0; p_data = 32'h0;
    last_ec = 1'b0; last_el = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Requests held during reset are never granted.
    repeat (3) begin
      settle();
      chk("rst_noboot_c_gnt", b_c_gnt, 1'b0);
      model_cycle();
    end

    // BOOT: CPU request held but locked out; RUN-reset instance serves it.
    rst_n = 1'b1; l_req = 1'b0;
    repeat (3) begin
      settle();
      chk("boot_c_gnt", c_gnt, 1'b0);
      chk("boot_cpu_run", cpu_run, 1'b0);
      chk("noboot_c_gnt", b_c_gnt, 1'b1);
      model_cycle();
    end

    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wdata = 32'hDEADBEEF;
    settle();
    chk("boot_l_gnt", l_gnt, 1'b1);
    chk("boot_m_en", m_en, 1'b1);
    chk("boot_m_addr", m_addr, 32'h100);
    model_cycle();

    l_req = 1'b0; l_we = 1'b0; boot_done = 1'b1;
    settle();
    chk("done_cycle_cpu_run", cpu_run, 1'b0);
    model_cycle();
    boot_done = 1'b0;

    c_we = 1'b0; c_addr = 32'h100;
    settle();
    chk("run_cpu_run", cpu_run, 1'b1);
    chk("run_c_gnt", c_gnt, 1'b1);
    model_cycle();
    c_req = 1'b0;
    settle();
    chk("run_c_rvalid", c_rvalid, 1'b1);
    chk("run_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("run_l_rvalid", l_rvalid, 1'b0);
    model_cycle();

    // Continuous contention: eight CPU grants, forced loader slot, CPU again.
    c_req = 1'b1; c_addr = 32'h0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("starve_c_gnt", c_gnt, i != 8);
      chk("starve_l_gnt", l_gnt, i == 8);
      model_cycle();
    end
    c_req = 1'b0; l_req = 1'b0;
    settle(); model_cycle();

    // Seed two words, then alternate reads between requesters.
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h10; c_wdata = 32'h11112222;
    settle(); model_cycle();
    c_req = 1'b0; c_we = 1'b0;
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h14; l_wdata = 32'h33334444;
    settle(); model_cycle();
    l_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      c_req = (i < 6) && (i % 2 == 0);
      l_req = (i < 6) && (i % 2 == 1);
      settle();
      if (i > 0) begin
        chk("alt_c_rvalid", c_rvalid, i % 2 == 1);
        chk("alt_l_rvalid", l_rvalid, i % 2 == 0);
        chk("alt_rdata", c_rdata, (i % 2 == 1) ? 32'h11112222 : 32'h33334444);
      end
      model_cycle();
    end

    // Random traffic; ungranted requests usually stay put, sometimes withdraw.
    repeat (400) begin
      if (!(c_req && !last_ec && $urandom_range(0, 7) != 0)) begin
        c_req   = $urandom_range(0, 3) != 0;
        c_we    = 1'($urandom_range(0, 1));
        c_be    = 4'($urandom_range(0, 15));
        c_addr  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
        c_wdata = $urandom;
      end
      if (!(l_req && !last_el && $urandom_range(0, 7) != 0)) begin
        l_req   = $urandom_range(0, 1) != 0;
        l_we    = 1'($urandom_range(0, 1));
        l_be    = 4'($urandom_range(0, 15));
        l_addr  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
        l_wdata = $urandom;
      end
      boot_done = $urandom_range(0, 15) == 0;
      settle();
      model_cycle();
    end

    // Reset lands on the cycle a loader read would return.
    boot_done = 1'b0; c_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h14;
    settle();
    chk("rr_l_gnt", l_gnt, 1'b1);
    model_cycle();
    rst_n = 1'b0; c_req = 1'b1;
    settle();
    chk("rr_l_rvalid", l_rvalid, 1'b0);
    chk("rr_m_en", m_en, 1'b0);
    chk("rr_cpu_run", cpu_run, 1'b0);
    model_cycle();
    settle(); model_cycle();
    rst_n = 1'b1; c_req = 1'b0; l_req = 1'b0;
    settle();
    chk("rr_after_l_rvalid", l_rvalid, 1'b0);
    model_cycle();
    settle(); model_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
